// File: rtl/integrate_dump.sv
// integrate_dump: signed fixed-point integrate-and-dump accumulator.
//
// It sums ACC_LEN consecutive valid samples per frame and emits one full-precision
// result per frame. The result is bit-grown by $clog2(ACC_LEN) bits and keeps the input
// binary point, so the sum cannot overflow. Frames are aligned by sync. Results are held
// in a one-entry output register with a valid/ready handshake. A result that completes
// while that register is still occupied is discarded and flagged on dropped.
//
// Optional feature macro: INTEGRATE_DUMP_DROP_CNT_EN adds the drop_cnt port, an 8-bit
// count of dropped results that saturates at 255.
//
// Ports:
//   clk       in   clock; all state changes on the rising edge
//   rst       in   asynchronous active-high reset
//   sync      in   frame alignment pulse; starts a new frame
//   din       in   input sample, N_BITS_IN bits, two's complement
//   din_vld   in   din qualifier
//   dout      out  frame sum, N_BITS_OUT bits, signed, BIN_PT_OUT fractional bits
//   dout_vld  out  dout holds an unconsumed result
//   dout_rdy  in   downstream accepts dout when dout_vld && dout_rdy
//   count     out  index of the next sample within the frame
//   dropped   out  one-cycle pulse when a completed result is discarded
//   drop_cnt  out  saturating count of dropped results (INTEGRATE_DUMP_DROP_CNT_EN only)
module integrate_dump #(
  parameter int unsigned N_BITS_IN = 8,
  parameter int unsigned BIN_PT_IN = 7,
  parameter int unsigned ACC_LEN   = 16
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         sync,
  input  logic [N_BITS_IN-1:0]                         din,
  input  logic                                         din_vld,
  output logic [N_BITS_IN+$clog2(ACC_LEN)-1:0]         dout,
  output logic                                         dout_vld,
  input  logic                                         dout_rdy,
  output logic [$clog2(ACC_LEN)-1:0]                   count,
`ifdef INTEGRATE_DUMP_DROP_CNT_EN
  output logic                                         dropped,
  output logic [7:0]                                   drop_cnt
`else
  output logic                                         dropped
`endif
);

  localparam int unsigned CntW       = $clog2(ACC_LEN);
  localparam int unsigned N_BITS_OUT = N_BITS_IN + CntW;
  localparam int unsigned BIN_PT_OUT = BIN_PT_IN;
  localparam logic [CntW-1:0] LastIdx = CntW'(ACC_LEN - 1);

  // Parameter sanity checks, evaluated at elaboration.
  if (ACC_LEN < 2) begin : g_bad_acc_len
    $error("integrate_dump: ACC_LEN must be at least 2");
  end
  if (BIN_PT_OUT > N_BITS_OUT) begin : g_bad_bin_pt
    $error("integrate_dump: binary point exceeds word width");
  end

  typedef enum logic [0:0] {StWaitSync, StAccum} state_e;

  state_e                  state_q, state_d;
  logic [N_BITS_OUT-1:0]   acc_q, acc_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [N_BITS_OUT-1:0]   dout_q, dout_d;
  logic                    dout_vld_q, dout_vld_d;
  logic                    dropped_q, dropped_d;

  logic [N_BITS_OUT-1:0]   din_sext;
  logic [N_BITS_OUT-1:0]   sum;
  logic                    dump;

  assign din_sext = {{(N_BITS_OUT - N_BITS_IN){din[N_BITS_IN-1]}}, din};
  assign sum      = acc_q + din_sext;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    dump       = 1'b0;

    if (sync) begin
      // A new frame starts here; a sample in the same cycle is its sample 0.
      state_d = StAccum;
      acc_d   = din_vld ? din_sext : '0;
      count_d = din_vld ? CntW'(1) : '0;
    end else if (state_q == StAccum && din_vld) begin
      if (count_q == LastIdx) begin
        dump    = 1'b1;
        acc_d   = '0;
        count_d = '0;
      end else begin
        acc_d   = sum;
        count_d = count_q + CntW'(1);
      end
    end
  end

  // Output register: a dump loads it when it is empty or is being consumed this cycle.
  always_comb begin
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    dropped_d  = 1'b0;

    if (dout_vld_q && dout_rdy) begin
      dout_vld_d = 1'b0;
    end
    if (dump) begin
      if (!dout_vld_q || dout_rdy) begin
        dout_d     = sum;
        dout_vld_d = 1'b1;
      end else begin
        dropped_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StWaitSync;
      acc_q      <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      dropped_q  <= dropped_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign count    = count_q;
  assign dropped  = dropped_q;

`ifdef INTEGRATE_DUMP_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (dropped_d && drop_cnt_q != 8'hFF) begin
      // Counted on the same edge that raises the dropped pulse.
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/integrate_dump.md
# integrate_dump

Signed fixed-point integrate-and-dump accumulator that sums ACC_LEN consecutive valid input samples and emits one full-precision result per frame. It sits directly upstream of `convert`: its output word is bit-grown (no overflow possible) with the binary point unchanged, and `convert` requantises it to the final format. Frames are aligned by a `sync` pulse. Results are held in a one-entry output register with a valid/ready handshake. Results that arrive while that register is still occupied are dropped and flagged.

## Interface
- N_BITS_IN, 8, input word width, two's complement
- BIN_PT_IN, 7, input binary point (fractional bits)
- ACC_LEN, 16, samples per frame, ≥ 2
- N_BITS_OUT (derived localparam, not overridable), N_BITS_IN + $clog2(ACC_LEN), output width
- BIN_PT_OUT (derived localparam), BIN_PT_IN, output binary point
- One clock; reset is asynchronous and active-high:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- sync  in  1  frame alignment pulse; starts a new frame
- din  in  N_BITS_IN  input sample
- din_vld  in  1  din qualifier
- dout  out  N_BITS_OUT  frame sum, signed, BIN_PT_OUT fractional bits
- dout_vld  out  1  dout holds an unconsumed result
- dout_rdy  in  1  downstream accepts dout when dout_vld && dout_rdy
- count  out  $clog2(ACC_LEN)  index of the next sample within the frame
- dropped  out  1  one-cycle pulse when a completed result is discarded

## Operation
- FSM states:
  - WAIT_SYNC (reset state): din_vld is ignored.
  - ACCUM: accumulates samples.
- Transitions:
  - sync in any state → ACCUM, with count=0 and the partial sum discarded.
  - If din_vld is high in the same cycle as sync, din becomes sample 0 of the new frame: acc=din, count=1.
  - There is no transition back to WAIT_SYNC except via rst.
- In ACCUM, each din_vld does acc += sext(din) and count += 1.
- Dump: on the din_vld with count == ACC_LEN-1:
  - The result acc+sext(din) goes to the output register.
  - acc is cleared to 0 and count wraps to 0.
- Output register:
  - It loads if it is empty, or if dout_vld && dout_rdy in the dump cycle (simultaneous consume and load). In that case dout_vld stays 1.
  - Otherwise the new result is discarded, dropped pulses for 1 cycle, and dout and dout_vld are unchanged.
- dout and dout_vld stay stable while dout_vld && !dout_rdy.
- After consumption with no new load, dout_vld goes to 0 and dout keeps its last value.
- Arithmetic: din is sign-extended to N_BITS_OUT. The full-width sum cannot overflow. No rounding or saturation is done here.
- Register reset values: state=WAIT_SYNC, acc=0, count=0, dout=0, dout_vld=0, dropped=0 (and drop_cnt=0 when configured).
- rst mid-frame discards everything immediately (asynchronous). The block then requires a new sync.

## Timing
- Latency: dump sample accepted on edge k → dout and dout_vld valid after edge k (visible in cycle k+1).
- Throughput: one sample per cycle, with no stalls. din has no ready; the upstream stage never waits.
- Minimum frame spacing: ACC_LEN cycles. Downstream must consume within ACC_LEN cycles of dout_vld to avoid drops.
- dropped is asserted in the cycle after the discarded dump sample, aligned with the would-be dout update.
- count is registered and reflects the frame state after each edge.

## Configuration
- INTEGRATE_DUMP_DROP_CNT_EN defined:
  - Adds output port drop_cnt (8 bits).
  - drop_cnt increments on each dropped pulse and saturates at 255.
  - It is cleared only by rst.
- Undefined: drop_cnt port and logic are absent, and only the dropped pulse remains.

## Test plan
All scenarios use N_BITS_IN=8, BIN_PT_IN=7, ACC_LEN=4, so N_BITS_OUT=10.
- Basic frame: sync, then 4 samples of 8'h40 (0.5) with dout_rdy=0 → dout=10'h100 (2.0), dout_vld=1 one cycle after the 4th sample, held stable for 10 cycles; count returns to 0.
- Sign extension: 4 samples of 8'h80 (−1.0) → dout=10'h200 (−4.0). Then 4 samples of 8'h7F → dout=10'h1FC.
- Pre-sync gating: after rst, 6 samples of 8'h7F without sync → dout_vld stays 0 and count stays 0. Then sync with din_vld=1 and din=8'h01, followed by 3 more 8'h01 → dout=10'h004.
- Mid-frame resync: 2 samples of 8'h40, then sync with din_vld=0, then 4 samples of 8'h01 → dout=10'h004 (the partial sum is discarded).
- Backpressure:
  - Hold dout_rdy=0 across two frames (10'h100, then 10'h004) → dropped pulses exactly 1 cycle, dout stays 10'h100, and drop_cnt=1 (macro defined).
  - Then dout_rdy=1 in the dump cycle of the third frame → the new result loads and dout_vld stays 1.
- Async reset: assert rst between clock edges after 2 samples → dout=0, dout_vld=0, count=0, dropped=0 immediately. After release, 4 samples without sync produce no output.
